// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multicycle control FSM:
// state encoding, opcodes, ALU operation encoding, datapath select codes,
// the per-state control word and small helper functions.
package multicycle_pkg;

    // FSM states; 4 bits, all 16 codes are used.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_LINK     = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    // Major opcodes (Instr[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation encoding.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } aluop_t;

    // Datapath select codes.
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMU      = 2'b11;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_A        = 2'b10;
    localparam logic [1:0] SRCA_ZERO     = 2'b11;
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

    // One control word issued per state.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        aluop_t     alu_op;
    } ctrl_word_t;

    // Control word with every enable off and every select at code 0.
    function automatic ctrl_word_t ctrl_idle();
        ctrl_word_t w;
        w.pc_write   = 1'b0;
        w.adr_src    = ADR_PC;
        w.mem_read   = 1'b0;
        w.mem_write  = 1'b0;
        w.ir_write   = 1'b0;
        w.reg_write  = 1'b0;
        w.result_src = RES_ALUOUT;
        w.alu_src_a  = SRCA_PC;
        w.alu_src_b  = SRCB_B;
        w.imm_src    = IMM_I;
        w.alu_op     = ALUOP_ADD;
        return w;
    endfunction

    // Branch decision from funct3 and the ALU compare flags.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       alu_lsb);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = alu_lsb;
            3'b101:  taken = ~alu_lsb;
            3'b110:  taken = alu_lsb;
            3'b111:  taken = ~alu_lsb;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // funct3 010/011 are not branch encodings.
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the controller and the shared
// instruction/data memory: request/address-select out, ready back.
interface multicycle_ctrl_if;
    logic mem_ready;
    logic AdrSrc;
    logic MemRead;
    logic MemWrite;

    // Controller side.
    modport master (input mem_ready, output AdrSrc, output MemRead, output MemWrite);
    // Memory side.
    modport slave  (output mem_ready, input AdrSrc, input MemRead, input MemWrite);
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the operation class from the FSM plus funct3,
// funct7b5 and op[5] onto the ALU operation code.
module alu_dec
    import multicycle_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [3:0] alu_control
);

    // Select the ALU operation; funct7b5 means SUB only for R-type, SRA for both shifts.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV32I multicycle datapath (shared memory port, IR,
// OldPC, A/B, ALUOut). One control word per state; stalls on mem_ready in
// FETCH, MEMREAD and MEMWRITE. Optional macro MULTICYCLE_CTRL_TRAP_EN adds
// a TRAP state for unknown opcodes and non-branch funct3 values, with an
// illegal_o output; without it unknown opcodes behave as NOPs.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              ALULsb,
    multicycle_ctrl_if.master mem,
    output logic [31:0]       pc_reset_val,
    output logic              PCWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [3:0]        ALUControl,
    output logic [3:0]        state_o
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    output logic              illegal_o
`endif
);

    state_t     state_r;
    state_t     next_state_s;
    ctrl_word_t word_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       adr_src_s;

    // State register; reset returns to FETCH and abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:    next_state_s = mem.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  next_state_s = S_MEMADR;
                    OP_RTYPE:  next_state_s = S_EXECR;
                    OP_ITYPE:  next_state_s = S_EXECI;
                    OP_BRANCH: next_state_s = S_BRANCH;
                    OP_JAL:    next_state_s = S_JAL;
                    OP_JALR:   next_state_s = S_JALR;
                    OP_LUI:    next_state_s = S_LUI;
                    OP_AUIPC:  next_state_s = S_AUIPC;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default:   next_state_s = S_TRAP;
`else
                    default:   next_state_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state_s = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state_s = mem.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = mem.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    next_state_s = S_ALUWB;
            S_EXECI:    next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_BRANCH:   next_state_s = branch_legal(funct3) ? S_FETCH : S_TRAP;
`else
            S_BRANCH:   next_state_s = S_FETCH;
`endif
            // JALR only forms its target in ALUOut, then shares the JAL/LINK tail.
            S_JALR:     next_state_s = S_JAL;
            S_JAL:      next_state_s = S_LINK;
            S_LINK:     next_state_s = S_FETCH;
            S_LUI:      next_state_s = S_FETCH;
            S_AUIPC:    next_state_s = S_ALUWB;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP:     next_state_s = S_TRAP;
`else
            S_TRAP:     next_state_s = S_FETCH;
`endif
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Control word for the current state (Moore, except FETCH ready gating and BRANCH PCWrite).
    always_comb begin
        word_s = ctrl_idle();
        case (state_r)
            S_FETCH: begin
                word_s.adr_src    = ADR_PC;
                word_s.mem_read   = 1'b1;
                word_s.alu_src_a  = SRCA_PC;
                word_s.alu_src_b  = SRCB_FOUR;
                word_s.alu_op     = ALUOP_ADD;
                word_s.result_src = RES_ALURESULT;
                word_s.ir_write   = mem.mem_ready;
                word_s.pc_write   = mem.mem_ready;
            end
            S_DECODE: begin
                // Speculative target into ALUOut; JAL needs the J immediate here.
                word_s.alu_src_a = SRCA_OLDPC;
                word_s.alu_src_b = SRCB_IMM;
                word_s.imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                word_s.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                word_s.alu_src_a = SRCA_A;
                word_s.alu_src_b = SRCB_IMM;
                word_s.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                word_s.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                word_s.adr_src  = ADR_ALUOUT;
                word_s.mem_read = 1'b1;
            end
            S_MEMWB: begin
                word_s.result_src = RES_DATA;
                word_s.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                word_s.adr_src   = ADR_ALUOUT;
                word_s.mem_write = 1'b1;
            end
            S_EXECR: begin
                word_s.alu_src_a = SRCA_A;
                word_s.alu_src_b = SRCB_B;
                word_s.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                word_s.alu_src_a = SRCA_A;
                word_s.alu_src_b = SRCB_IMM;
                word_s.imm_src   = IMM_I;
                word_s.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                word_s.result_src = RES_ALUOUT;
                word_s.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                word_s.alu_src_a  = SRCA_A;
                word_s.alu_src_b  = SRCB_B;
                word_s.alu_op     = ALUOP_BRANCH;
                word_s.result_src = RES_ALUOUT;
                word_s.pc_write   = branch_taken(funct3, Zero, ALULsb);
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC + 4.
                word_s.alu_src_a  = SRCA_OLDPC;
                word_s.alu_src_b  = SRCB_FOUR;
                word_s.imm_src    = IMM_J;
                word_s.alu_op     = ALUOP_ADD;
                word_s.result_src = RES_ALUOUT;
                word_s.pc_write   = 1'b1;
            end
            S_JALR: begin
                word_s.alu_src_a = SRCA_A;
                word_s.alu_src_b = SRCB_IMM;
                word_s.imm_src   = IMM_I;
                word_s.alu_op    = ALUOP_ADD;
            end
            S_LINK: begin
                word_s.alu_src_a  = SRCA_OLDPC;
                word_s.alu_src_b  = SRCB_FOUR;
                word_s.alu_op     = ALUOP_ADD;
                word_s.result_src = RES_ALURESULT;
                word_s.reg_write  = 1'b1;
            end
            S_LUI: begin
                word_s.result_src = RES_IMMU;
                word_s.reg_write  = 1'b1;
            end
            S_AUIPC: begin
                word_s.alu_src_a = SRCA_OLDPC;
                word_s.alu_src_b = SRCB_IMM;
                word_s.alu_op    = ALUOP_ADD;
            end
            S_TRAP:  word_s = ctrl_idle();
            default: word_s = ctrl_idle();
        endcase
    end

    // Force every enable low while reset is held; selects pass through.
    always_comb begin
        if (reset) begin
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
        end else begin
            PCWrite     = word_s.pc_write;
            IRWrite     = word_s.ir_write;
            RegWrite    = word_s.reg_write;
            mem_read_s  = word_s.mem_read;
            mem_write_s = word_s.mem_write;
        end
    end

    assign adr_src_s    = word_s.adr_src;
    assign mem.AdrSrc   = adr_src_s;
    assign mem.MemRead  = mem_read_s;
    assign mem.MemWrite = mem_write_s;

    assign ResultSrc    = word_s.result_src;
    assign ALUSrcA      = word_s.alu_src_a;
    assign ALUSrcB      = word_s.alu_src_b;
    assign ImmSrc       = word_s.imm_src;
    assign state_o      = state_r;
    assign pc_reset_val = RESET_PC;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign illegal_o = (state_r == S_TRAP);
`endif

    alu_dec u_alu_dec (
        .alu_op      (word_s.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op_b5       (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset behaviour, instruction flows
// with hand-computed cycle counts and control values, memory stalls,
// branch decisions and reset during a store.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        ALULsb;
    logic [31:0] pc_reset_val;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  state_o;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic        illegal_o;
`endif

    multicycle_ctrl_if mem_if ();

    multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .ALULsb       (ALULsb),
        .mem          (mem_if),
        .pc_reset_val (pc_reset_val),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .state_o      (state_o)
`ifdef MULTICYCLE_CTRL_TRAP_EN
        ,
        .illegal_o    (illegal_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-instruction observations.
    int         cyc, rw, mrd, mwr, pcw_x;
    logic       pcw_br;
    logic [3:0] alu_br, alu_ex;
    logic [1:0] imm_ma;
    logic       done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Run one instruction starting at a FETCH sample point until FETCH returns.
    // The memory model drops mem_ready for nwait cycles in MEMREAD/MEMWRITE.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic lsb, input int nwait);
        int waits;
        waits  = 0;
        cyc    = 0; rw = 0; mrd = 0; mwr = 0; pcw_x = 0;
        pcw_br = 1'bx; alu_br = 4'hf; alu_ex = 4'hf; imm_ma = 2'bxx;
        done   = 1'b0;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; ALULsb = lsb;
        mem_if.mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (state_o == 4'd3 || state_o == 4'd5) begin
                    mem_if.mem_ready = (waits >= nwait);
                    waits++;
                end else begin
                    mem_if.mem_ready = 1'b1;
                end
                #1;
                if (state_o == 4'd0) begin
                    done = 1'b1;
                    break;
                end
            end
            cyc++;
            if (RegWrite) rw++;
            if (mem_if.MemRead && mem_if.AdrSrc) mrd++;
            if (mem_if.MemWrite) mwr++;
            if (state_o != 4'd0 && PCWrite) pcw_x++;
            if (state_o == 4'd9) begin
                pcw_br = PCWrite;
                alu_br = ALUControl;
            end
            if (state_o == 4'd6 || state_o == 4'd7) alu_ex = ALUControl;
            if (state_o == 4'd2) imm_ma = ImmSrc;
        end
        chk({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; ALULsb = 1'b0; mem_if.mem_ready = 1'b0;

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", state_o, 4'd0);
        chk("rst_enables", {PCWrite, mem_if.MemRead, mem_if.MemWrite, IRWrite, RegWrite}, 5'b00000);
        chk("pc_reset_val", pc_reset_val, 32'h0000_0000);

        // Release with memory ready: first FETCH cycle, then add flow step by step.
        @(negedge clk);
        reset = 1'b0; mem_if.mem_ready = 1'b1;
        #1;
        chk("fetch_state", state_o, 4'd0);
        chk("fetch_irwrite", IRWrite, 1'b1);
        chk("fetch_pcwrite", PCWrite, 1'b1);
        chk("fetch_word", {mem_if.MemRead, mem_if.AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl},
            {1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 4'b0000});
        tick();
        chk("decode_state", state_o, 4'd1);
        chk("decode_word", {ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IRWrite},
            {2'b01, 2'b01, 2'b10, 4'b0000, 1'b0});
        tick();
        chk("execr_state", state_o, 4'd6);
        chk("execr_word", {ALUSrcA, ALUSrcB, ALUControl}, {2'b10, 2'b00, 4'b0000});
        tick();
        chk("aluwb_state", state_o, 4'd8);
        chk("aluwb_word", {RegWrite, ResultSrc}, {1'b1, 2'b00});
        tick();
        chk("add_back_fetch", {state_o, RegWrite}, {4'd0, 1'b0});

        // R-type and I-type ALU decodes.
        run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("add_cycles", cyc, 4);
        chk("add_regwrite", rw, 1);
        chk("add_alu", alu_ex, 4'b0000);
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0);
        chk("sub_alu", alu_ex, 4'b0001);
        run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0);
        chk("addi_f7_alu", alu_ex, 4'b0000);
        run_instr("srai", 7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 0);
        chk("srai_alu", alu_ex, 4'b1001);
        run_instr("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 0);
        chk("or_alu", alu_ex, 4'b0011);

        // Load with three stall cycles in MEMREAD.
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3);
        chk("lw_cycles", cyc, 8);
        chk("lw_memread_cycles", mrd, 4);
        chk("lw_regwrite", rw, 1);
        chk("lw_imm", imm_ma, 2'b00);
        chk("lw_memwrite", mwr, 0);

        // Store with one stall cycle in MEMWRITE.
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1);
        chk("sw_cycles", cyc, 5);
        chk("sw_memwrite_cycles", mwr, 2);
        chk("sw_regwrite", rw, 0);
        chk("sw_imm", imm_ma, 2'b01);

        // Branches.
        run_instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 0);
        chk("bne_z1_pcwrite", pcw_br, 1'b0);
        chk("bne_z1_cycles", cyc, 3);
        run_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 0);
        chk("bne_z0_pcwrite", pcw_br, 1'b1);
        run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0);
        chk("beq_z1", {pcw_br, alu_br}, {1'b1, 4'b0001});
        run_instr("bltu_l1", 7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, 0);
        chk("bltu_l1", {pcw_br, alu_br}, {1'b1, 4'b0110});
        run_instr("bge_l1", 7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 0);
        chk("bge_l1", {pcw_br, alu_br}, {1'b0, 4'b0101});
        run_instr("blt_l1", 7'b1100011, 3'b100, 1'b0, 1'b1, 1'b1, 0);
        chk("blt_l1", {pcw_br, alu_br}, {1'b1, 4'b0101});
`ifndef MULTICYCLE_CTRL_TRAP_EN
        run_instr("br_f3_010", 7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 0);
        chk("br_f3_010_pcwrite", pcw_br, 1'b0);
`endif

        // Jumps and upper-immediate forms.
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("jal", {cyc[3:0], rw[3:0], pcw_x[3:0]}, {4'd4, 4'd1, 4'd1});
        run_instr("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("jalr", {cyc[3:0], rw[3:0], pcw_x[3:0]}, {4'd5, 4'd1, 4'd1});
        run_instr("lui", 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("lui", {cyc[3:0], rw[3:0]}, {4'd3, 4'd1});
        run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 0);
        chk("auipc", {cyc[3:0], rw[3:0]}, {4'd4, 4'd1});

        // Reset during a stalled store.
        op = 7'b0100011; funct3 = 3'b010; mem_if.mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        #1;
        chk("sw_stall_state", {state_o, mem_if.MemWrite}, {4'd5, 1'b1});
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_held_memwrite", mem_if.MemWrite, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_abort_state", state_o, 4'd0);
        chk("rst_abort_word", {mem_if.MemWrite, mem_if.MemRead, IRWrite, PCWrite},
            {1'b0, 1'b1, 1'b0, 1'b0});
        tick();
        chk("fetch_hold_state", state_o, 4'd0);
        mem_if.mem_ready = 1'b1;
        #1;
        chk("fetch_ready_irwrite", IRWrite, 1'b1);

        // Unknown opcode.
        op = 7'b1111111;
        tick();
        chk("unk_decode", state_o, 4'd1);
        tick();
`ifdef MULTICYCLE_CTRL_TRAP_EN
        chk("unk_trap", {state_o, illegal_o}, {4'd15, 1'b1});
        chk("unk_trap_enables", {PCWrite, mem_if.MemRead, mem_if.MemWrite, IRWrite, RegWrite}, 5'b00000);
        tick();
        chk("unk_trap_hold", state_o, 4'd15);
`else
        chk("unk_nop_fetch", {state_o, IRWrite}, {4'd0, 1'b1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
